// File: rtl/mem_write_buffer.sv
// Store buffer between the MEM stage and the AXI write channels. It holds stores in a circular queue until their B response arrives.
// Optional store-to-load forwarding is built only when WBUF_FWD_EN is defined.
module mem_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int PW        = $clog2(DEPTH) + 1
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    // store request from MEM
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] Write_data,
    input  logic [STRB_W-1:0]     Write_strb,
    output logic                  Wr_Req_Ack,
    // load hazard check
    input  logic [ADDR_WIDTH-1:0] Rd_Address,
    input  logic                  Rd_Check_Valid,
    output logic                  Rd_Hazard,
    output logic                  Rd_Fwd_Valid,
    output logic [DATA_WIDTH-1:0] Rd_Fwd_Data,
    // status
    output logic                  Wbuf_Empty,
    output logic [PW-1:0]         Wbuf_Count,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [3:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_W-1:0]     M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    // AXI write response
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    localparam int IW  = $clog2(DEPTH);
    localparam int OFF = $clog2(STRB_W);
    localparam int TW  = ADDR_WIDTH - OFF;

    // Only the word address is kept; the byte offset is implied by alignment.
    typedef struct packed {
        logic [TW-1:0]         tag;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   aw_ptr_q, aw_ptr_d;
    logic [PW-1:0]   w_ptr_q,  w_ptr_d;
    logic [PW-1:0]   b_ptr_q,  b_ptr_d;
    logic            bready_q, bready_d;

    logic [PW-1:0]   count;
    logic            full;
    logic            wr_ack;
    logic            aw_valid;
    logic            w_valid;
    logic            b_fire;
    logic [IW-1:0]   aw_idx;
    logic [IW-1:0]   w_idx;
    logic [TW-1:0]   rd_tag;
    logic            any_match;
    logic            unused_bits;

    assign unused_bits = ^{Address[OFF-1:0], Rd_Address[OFF-1:0]};

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    always_comb begin
        count    = wr_ptr_q - b_ptr_q;
        full     = (count == PW'(DEPTH));
        // NOTE: the ack depends on the registered full flag. A B response in the same cycle frees the slot only from the next cycle, so no path runs from B to the ack.
        wr_ack   = MemWrite & ~full;
        aw_valid = (aw_ptr_q != wr_ptr_q);
        w_valid  = (w_ptr_q  != wr_ptr_q);
        // An entry is released only after its AW and its W have both been issued.
        b_fire   = M_AXI_BVALID & bready_q
                   & (b_ptr_q != aw_ptr_q) & (b_ptr_q != w_ptr_q);

        wr_ptr_d = wr_ptr_q + PW'(wr_ack);
        aw_ptr_d = aw_ptr_q + PW'(aw_valid & M_AXI_AWREADY);
        w_ptr_d  = w_ptr_q  + PW'(w_valid  & M_AXI_WREADY);
        b_ptr_d  = b_ptr_q  + PW'(b_fire);
        bready_d = 1'b1;

        wr_entry.tag  = Address[ADDR_WIDTH-1:OFF];
        wr_entry.data = Write_data;
        wr_entry.strb = Write_strb;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr_q <= '0;
            aw_ptr_q <= '0;
            w_ptr_q  <= '0;
            b_ptr_q  <= '0;
            bready_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            aw_ptr_q <= aw_ptr_d;
            w_ptr_q  <= w_ptr_d;
            b_ptr_q  <= b_ptr_d;
            bready_q <= bready_d;
        end
    end

    // NOTE: the payload array has no reset. The pointers alone decide which slots are live, and every output that reads the array is gated by a valid signal.
    always_ff @(posedge M_AXI_ACLK) begin
        if (wr_ack) begin
            mem_q[wr_ptr_q[IW-1:0]] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // AXI channels
    // ------------------------------------------------------------------
    always_comb begin
        aw_idx        = aw_ptr_q[IW-1:0];
        w_idx         = w_ptr_q[IW-1:0];
        M_AXI_AWVALID = aw_valid;
        M_AXI_AWADDR  = aw_valid ? {mem_q[aw_idx].tag, {OFF{1'b0}}} : '0;
        M_AXI_WVALID  = w_valid;
        M_AXI_WLAST   = w_valid;
        M_AXI_WDATA   = w_valid ? mem_q[w_idx].data : '0;
        M_AXI_WSTRB   = w_valid ? mem_q[w_idx].strb : '0;
    end

    assign M_AXI_AWLEN  = 4'd0;
    assign M_AXI_AWSIZE = 3'(OFF);
    assign M_AXI_BREADY = bready_q;
    assign Wr_Req_Ack   = wr_ack;
    assign Wbuf_Count   = count;
    assign Wbuf_Empty   = (count == '0);

    // ------------------------------------------------------------------
    // Load hazard check across every retained entry, oldest to youngest
    // ------------------------------------------------------------------
`ifdef WBUF_FWD_EN
    logic [DATA_WIDTH-1:0] young_data;
    logic [STRB_W-1:0]     young_strb;
`endif

    always_comb begin
        logic [IW-1:0] idx;
        rd_tag    = Rd_Address[ADDR_WIDTH-1:OFF];
        any_match = 1'b0;
`ifdef WBUF_FWD_EN
        young_data = '0;
        young_strb = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = b_ptr_q[IW-1:0] + IW'(k);
            if ((PW'(k) < count) && (mem_q[idx].tag == rd_tag)) begin
                any_match = 1'b1;
`ifdef WBUF_FWD_EN
                // A later k is younger, so the last hit wins.
                young_data = mem_q[idx].data;
                young_strb = mem_q[idx].strb;
`endif
            end
        end
    end

`ifdef WBUF_FWD_EN
    always_comb begin
        Rd_Fwd_Valid = Rd_Check_Valid & any_match & (&young_strb);
        Rd_Hazard    = Rd_Check_Valid & any_match & ~(&young_strb);
        Rd_Fwd_Data  = Rd_Fwd_Valid ? young_data : '0;
    end
`else
    assign Rd_Hazard    = Rd_Check_Valid & any_match;
    assign Rd_Fwd_Valid = 1'b0;
    assign Rd_Fwd_Data  = '0;
`endif

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with the default parameters (DEPTH=4, 32-bit address and data).
// Forwarding expectations follow WBUF_FWD_EN.
module tb_mem_write_buffer;

`ifdef WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        M_AXI_ACLK;
    logic        M_AXI_ARESETN;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Wr_Req_Ack;
    logic [31:0] Rd_Address;
    logic        Rd_Check_Valid;
    logic        Rd_Hazard;
    logic        Rd_Fwd_Valid;
    logic [31:0] Rd_Fwd_Data;
    logic        Wbuf_Empty;
    logic [2:0]  Wbuf_Count;
    logic [31:0] M_AXI_AWADDR;
    logic [3:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    int n_vec = 0;
    int n_err = 0;

    mem_write_buffer dut (
        .M_AXI_ACLK     (M_AXI_ACLK),
        .M_AXI_ARESETN  (M_AXI_ARESETN),
        .Address        (Address),
        .MemWrite       (MemWrite),
        .Write_data     (Write_data),
        .Write_strb     (Write_strb),
        .Wr_Req_Ack     (Wr_Req_Ack),
        .Rd_Address     (Rd_Address),
        .Rd_Check_Valid (Rd_Check_Valid),
        .Rd_Hazard      (Rd_Hazard),
        .Rd_Fwd_Valid   (Rd_Fwd_Valid),
        .Rd_Fwd_Data    (Rd_Fwd_Data),
        .Wbuf_Empty     (Wbuf_Empty),
        .Wbuf_Count     (Wbuf_Count),
        .M_AXI_AWADDR   (M_AXI_AWADDR),
        .M_AXI_AWLEN    (M_AXI_AWLEN),
        .M_AXI_AWSIZE   (M_AXI_AWSIZE),
        .M_AXI_AWVALID  (M_AXI_AWVALID),
        .M_AXI_AWREADY  (M_AXI_AWREADY),
        .M_AXI_WDATA    (M_AXI_WDATA),
        .M_AXI_WSTRB    (M_AXI_WSTRB),
        .M_AXI_WLAST    (M_AXI_WLAST),
        .M_AXI_WVALID   (M_AXI_WVALID),
        .M_AXI_WREADY   (M_AXI_WREADY),
        .M_AXI_BVALID   (M_AXI_BVALID),
        .M_AXI_BREADY   (M_AXI_BREADY)
    );

    initial begin
        M_AXI_ACLK = 1'b0;
        forever #5 M_AXI_ACLK = ~M_AXI_ACLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled 1 unit later, well away from the edge.
    task automatic tick();
        @(posedge M_AXI_ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        MemWrite   = 1'b1;
        Address    = a;
        Write_data = d;
        Write_strb = s;
    endtask

    task automatic rd(input logic [31:0] a, input logic v);
        Rd_Address     = a;
        Rd_Check_Valid = v;
    endtask

    initial begin
        M_AXI_ARESETN  = 1'b0;
        Address        = '0;
        MemWrite       = 1'b0;
        Write_data     = '0;
        Write_strb     = '0;
        Rd_Address     = '0;
        Rd_Check_Valid = 1'b0;
        M_AXI_AWREADY  = 1'b0;
        M_AXI_WREADY   = 1'b0;
        M_AXI_BVALID   = 1'b0;

        // ---------------- reset values ----------------
        #2;
        check("rst_awvalid", 32'(M_AXI_AWVALID), 0);
        check("rst_wvalid",  32'(M_AXI_WVALID), 0);
        check("rst_wlast",   32'(M_AXI_WLAST), 0);
        check("rst_bready",  32'(M_AXI_BREADY), 0);
        check("rst_ack",     32'(Wr_Req_Ack), 0);
        check("rst_hazard",  32'(Rd_Hazard), 0);
        check("rst_fwdv",    32'(Rd_Fwd_Valid), 0);
        check("rst_fwdd",    Rd_Fwd_Data, 0);
        check("rst_empty",   32'(Wbuf_Empty), 1);
        check("rst_count",   32'(Wbuf_Count), 0);
        check("rst_awaddr",  M_AXI_AWADDR, 0);
        check("rst_wdata",   M_AXI_WDATA, 0);
        check("rst_wstrb",   32'(M_AXI_WSTRB), 0);
        check("awlen",       32'(M_AXI_AWLEN), 0);
        check("awsize",      32'(M_AXI_AWSIZE), 2);
        @(negedge M_AXI_ACLK);
        @(negedge M_AXI_ACLK);
        M_AXI_ARESETN = 1'b1;
        tick();
        check("bready_up", 32'(M_AXI_BREADY), 1);

        // ---------------- single store, full round trip ----------------
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        store(32'h1000, 32'hDEADBEEF, 4'hF);
        settle();
        check("t1_ack", 32'(Wr_Req_Ack), 1);
        check("t1_awv_pre", 32'(M_AXI_AWVALID), 0);
        tick();
        MemWrite = 1'b0;
        settle();
        check("t1_awvalid", 32'(M_AXI_AWVALID), 1);
        check("t1_wvalid",  32'(M_AXI_WVALID), 1);
        check("t1_wlast",   32'(M_AXI_WLAST), 1);
        check("t1_awaddr",  M_AXI_AWADDR, 32'h1000);
        check("t1_wdata",   M_AXI_WDATA, 32'hDEADBEEF);
        check("t1_wstrb",   32'(M_AXI_WSTRB), 32'hF);
        check("t1_count1",  32'(Wbuf_Count), 1);
        check("t1_empty0",  32'(Wbuf_Empty), 0);
        tick();
        M_AXI_BVALID = 1'b1;
        settle();
        check("t1_awv_done", 32'(M_AXI_AWVALID), 0);
        check("t1_wv_done",  32'(M_AXI_WVALID), 0);
        check("t1_count_iss", 32'(Wbuf_Count), 1);
        tick();
        settle();
        check("t1_count0", 32'(Wbuf_Count), 0);
        check("t1_empty1", 32'(Wbuf_Empty), 1);
        // a stray B response while nothing is outstanding is dropped
        tick();
        M_AXI_BVALID = 1'b0;
        settle();
        check("stray_b_count", 32'(Wbuf_Count), 0);

        // ---------------- fill to DEPTH, fifth store stalls ----------------
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h1100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            settle();
            check($sformatf("t2_ack%0d", i), 32'(Wr_Req_Ack), 1);
            tick();
        end
        store(32'h1110, 32'hA4, 4'hF);
        settle();
        check("t2_full_cnt", 32'(Wbuf_Count), 4);
        check("t2_ack4_full", 32'(Wr_Req_Ack), 0);
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b1;
        settle();
        check("t2_ack_same_b", 32'(Wr_Req_Ack), 0);
        tick();
        M_AXI_BVALID = 1'b0;
        settle();
        check("t2_cnt_freed", 32'(Wbuf_Count), 3);
        check("t2_ack_next",  32'(Wr_Req_Ack), 1);
        tick();
        MemWrite = 1'b0;
        settle();
        check("t2_cnt_refill", 32'(Wbuf_Count), 4);
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        settle();
        check("t2_drained", 32'(Wbuf_Count), 0);
        check("t2_empty",   32'(Wbuf_Empty), 1);

        // ---------------- W leads AW, across the pointer wrap ----------------
        M_AXI_WREADY = 1'b1;
        store(32'h1000, 32'h11, 4'hF);
        tick();
        store(32'h1004, 32'h22, 4'hF);
        tick();
        store(32'h1008, 32'h33, 4'hF);
        tick();
        MemWrite     = 1'b0;
        M_AXI_BVALID = 1'b1;
        settle();
        check("t3_wdata_lead", M_AXI_WDATA, 32'h33);
        check("t3_awaddr0",    M_AXI_AWADDR, 32'h1000);
        check("t3_cnt_hold",   32'(Wbuf_Count), 3);
        tick();
        M_AXI_BVALID = 1'b0;
        settle();
        check("t3_wv_done",  32'(M_AXI_WVALID), 0);
        check("t3_awv_pend", 32'(M_AXI_AWVALID), 1);
        check("t3_no_b_adv", 32'(Wbuf_Count), 3);
        M_AXI_AWREADY = 1'b1;
        check("t3_aw_order0", M_AXI_AWADDR, 32'h1000);
        tick();
        check("t3_aw_order1", M_AXI_AWADDR, 32'h1004);
        tick();
        check("t3_aw_order2", M_AXI_AWADDR, 32'h1008);
        tick();
        M_AXI_AWREADY = 1'b0;
        check("t3_awv_end", 32'(M_AXI_AWVALID), 0);
        check("t3_cnt_issued", 32'(Wbuf_Count), 3);
        M_AXI_BVALID = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        M_AXI_BVALID = 1'b0;
        M_AXI_WREADY = 1'b0;
        settle();
        check("t3_empty", 32'(Wbuf_Empty), 1);

        // ---------------- hazard / forwarding ----------------
        store(32'h2004, 32'hCAFEF00D, 4'hF);
        tick();
        MemWrite = 1'b0;
        rd(32'h2006, 1'b1);
        settle();
        check("t4_hazard", 32'(Rd_Hazard), FWD ? 0 : 1);
        check("t4_fwdv",   32'(Rd_Fwd_Valid), FWD ? 1 : 0);
        check("t4_fwdd",   Rd_Fwd_Data, FWD ? 32'hCAFEF00D : 32'h0);
        rd(32'h2008, 1'b1);
        settle();
        check("t4_nomatch", 32'(Rd_Hazard), 0);
        rd(32'h2004, 1'b0);
        settle();
        check("t4_novalid", 32'(Rd_Hazard), 0);
        // a store entering this cycle is not yet visible to the check
        store(32'h2010, 32'h55, 4'h3);
        rd(32'h2010, 1'b1);
        settle();
        check("t4_same_cyc", 32'(Rd_Hazard), 0);
        tick();
        MemWrite = 1'b0;
        settle();
        check("t4_partial", 32'(Rd_Hazard), 1);
        check("t4_partial_fv", 32'(Rd_Fwd_Valid), 0);

        // youngest of two stores to one word has partial strobes
        rd(32'h3000, 1'b0);
        store(32'h3000, 32'hFFFFFFFF, 4'hF);
        tick();
        store(32'h3000, 32'h000000AA, 4'h1);
        tick();
        MemWrite = 1'b0;
        rd(32'h3000, 1'b1);
        settle();
        check("t5_young_hz", 32'(Rd_Hazard), 1);
        check("t5_young_fv", 32'(Rd_Fwd_Valid), 0);
        check("t5_full_cnt", 32'(Wbuf_Count), 4);

        // issued but unacknowledged entries are still checked
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        rd(32'h2006, 1'b1);
        settle();
        check("t5_issued_awv", 32'(M_AXI_AWVALID), 0);
        check("t5_issued_hz",  32'(Rd_Hazard), FWD ? 0 : 1);
        check("t5_issued_fv",  32'(Rd_Fwd_Valid), FWD ? 1 : 0);
        rd(32'h0, 1'b0);
        M_AXI_BVALID = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        M_AXI_BVALID = 1'b0;
        settle();
        check("t5_empty", 32'(Wbuf_Empty), 1);

        // ---------------- reset mid-operation ----------------
        store(32'h5000, 32'h1, 4'hF);
        tick();
        store(32'h5004, 32'h2, 4'hF);
        tick();
        store(32'h5008, 32'h3, 4'hF);
        tick();
        MemWrite = 1'b0;
        settle();
        check("t6_pre_awv", 32'(M_AXI_AWVALID), 1);
        check("t6_pre_cnt", 32'(Wbuf_Count), 3);
        M_AXI_ARESETN = 1'b0;
        M_AXI_BVALID  = 1'b1;
        settle();
        check("t6_rst_awv",   32'(M_AXI_AWVALID), 0);
        check("t6_rst_wv",    32'(M_AXI_WVALID), 0);
        check("t6_rst_empty", 32'(Wbuf_Empty), 1);
        check("t6_rst_cnt",   32'(Wbuf_Count), 0);
        check("t6_rst_bready", 32'(M_AXI_BREADY), 0);
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        @(negedge M_AXI_ACLK);
        M_AXI_ARESETN = 1'b1;
        tick();
        tick();
        check("t6_post_cnt",   32'(Wbuf_Count), 0);
        check("t6_post_empty", 32'(Wbuf_Empty), 1);
        check("t6_post_awv",   32'(M_AXI_AWVALID), 0);
        M_AXI_BVALID  = 1'b0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        store(32'h4002, 32'h77, 4'hF);
        tick();
        MemWrite = 1'b0;
        settle();
        check("t6_new_awaddr", M_AXI_AWADDR, 32'h4000);
        check("t6_new_wdata",  M_AXI_WDATA, 32'h77);
        check("t6_new_cnt",    32'(Wbuf_Count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Parametrised store buffer between the MEM stage and the AXI write channel, replacing the fixed two-entry address/data FIFO pair in the cache wrapper. Stores are accepted in one cycle, held in a DEPTH-entry circular queue, and issued in order on independent AW and W channels. Each entry is retained until its B response returns. Load addresses are checked against all retained entries for read-after-write hazards, with optional store-to-load forwarding.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; 32 or 64; STRB_W = DATA_WIDTH/8
- Clock and reset: one clock; reset is asynchronous and active-low.
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- Address  in  ADDR_WIDTH  store byte address
- MemWrite  in  1  store request valid
- Write_data  in  DATA_WIDTH  store data
- Write_strb  in  STRB_W  byte enables
- Wr_Req_Ack  out  1  store accepted this cycle
- Rd_Address  in  ADDR_WIDTH  load address under check
- Rd_Check_Valid  in  1  load check request
- Rd_Hazard  out  1  load must stall
- Rd_Fwd_Valid  out  1  forwarded data valid (WBUF_FWD_EN only; otherwise tied 0)
- Rd_Fwd_Data  out  DATA_WIDTH  forwarded data (WBUF_FWD_EN only; otherwise tied 0)
- Wbuf_Empty  out  1  no retained entries
- Wbuf_Count  out  $clog2(DEPTH)+1  retained entries
- M_AXI_AWADDR  out  ADDR_WIDTH  write address, aligned to STRB_W
- M_AXI_AWLEN  out  4  constant 0
- M_AXI_AWSIZE  out  3  constant $clog2(STRB_W)
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
- M_AXI_WDATA  out  DATA_WIDTH  write data
- M_AXI_WSTRB  out  STRB_W  write strobes
- M_AXI_WLAST  out  1  equal to WVALID
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  W handshake
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready

## Operation
- Pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
  - wr_ptr: enqueue
  - aw_ptr: next AW to issue
  - w_ptr: next W to issue
  - b_ptr: oldest entry awaiting B
- Wbuf_Count = wr_ptr − b_ptr. Full when Wbuf_Count == DEPTH. Wbuf_Empty = (Wbuf_Count == 0).
- Wr_Req_Ack = MemWrite & ~full, where full is the registered value. A B response in the same cycle does not free a slot for that cycle's store.
- On ack: the entry at wr_ptr stores the address (aligned), data and strobes; wr_ptr increments.
- AW channel:
  - M_AXI_AWVALID = (aw_ptr != wr_ptr); payload comes from entry[aw_ptr].
  - aw_ptr increments on AWVALID & AWREADY.
- W channel:
  - M_AXI_WVALID = (w_ptr != wr_ptr); payload comes from entry[w_ptr].
  - w_ptr increments on handshake. AW and W progress independently; W may lead AW.
- B channel:
  - BVALID & BREADY with b_ptr != aw_ptr and b_ptr != w_ptr: b_ptr increments and the entry is freed.
  - A B response with no issued entry is dropped.
- Hazard check: compare Rd_Address[ADDR_WIDTH-1:$clog2(STRB_W)] against every entry between b_ptr and wr_ptr, including entries already issued but not yet acknowledged.
  - Without WBUF_FWD_EN: Rd_Hazard = Rd_Check_Valid & any match.
- Entries written in the same cycle as the check are not compared. Ordering is guaranteed by a one-cycle MEM-stage gap.
- Reset mid-operation discards all entries and any partially issued AW/W.

## Timing
- Reset values: all pointers 0; AWVALID, WVALID, WLAST, BREADY, Wr_Req_Ack (with MemWrite=0), Rd_Hazard, Rd_Fwd_Valid = 0; Wbuf_Empty = 1; Wbuf_Count = 0; AWADDR, WDATA, WSTRB, Rd_Fwd_Data = 0.
- BREADY is registered and goes to 1 on the first clock after reset release.
- Enqueue to AWVALID/WVALID: 1 cycle. Throughput: 1 store/cycle when AWREADY and WREADY are held high.
- AWVALID and WVALID are stable until their handshake, and their payloads do not change while valid.
- Rd_Hazard, Rd_Fwd_Valid and Rd_Fwd_Data are combinational from Rd_Address and registered state.
- Wrap-around: pointer wrap bit toggles at DEPTH; full/empty are decided by the wrap bit.

## Configuration
- WBUF_FWD_EN defined: the youngest matching entry (closest to wr_ptr) is selected.
  - If its strobes are all ones: Rd_Fwd_Valid=1, Rd_Fwd_Data = its data, Rd_Hazard=0.
  - If its strobes are partial: Rd_Hazard=1, Rd_Fwd_Valid=0.
- WBUF_FWD_EN undefined: no forwarding logic is built; Rd_Fwd_Valid and Rd_Fwd_Data are tied 0; any match asserts Rd_Hazard.

## Test plan
- Store 0x1000/0xDEADBEEF/0xF with AWREADY=WREADY=1 and BVALID 2 cycles later -> AWVALID and WVALID one cycle after ack; Wbuf_Count 1 → 0; Wbuf_Empty returns to 1.
- DEPTH=4, AWREADY=0, 5 back-to-back stores -> 4 acks, 5th Wr_Req_Ack=0; a B response in the same cycle does not ack it; ack follows on the next cycle after a slot frees.
- WREADY high, AWREADY low for 3 cycles -> W leads by 3 beats; the AW order matches 0x1000, 0x1004, 0x1008; b_ptr does not advance before AW.
- Pending store 0x2004 full strobe; check Rd_Address 0x2006 -> without the macro Rd_Hazard=1; with WBUF_FWD_EN Rd_Fwd_Valid=1 and data equals the stored word.
- Two stores to 0x3000 (0xFFFFFFFF, then 0x000000AA with strobe 0x1) under WBUF_FWD_EN -> youngest entry partial, so Rd_Hazard=1.
- Assert reset with 3 entries pending and AWVALID high -> all valids 0 immediately, Wbuf_Empty=1, no B response consumed after release.
